program_ram_loader: RTL and testbench

Writable 16×4 program store for the 4-bit CPU, replacing the fixed program ROM so programs can be written at run time instead of rebuilt. A host writes instruction nibbles over a valid/ready stream. The CPU fetch port reads the stored program combinationally, like the ROM it replaces. During a load, the block holds the CPU and forces the fetch output to the NOP/CLR opcode.

---
 rtl/program_ram_loader_if.sv | 29 ++
 rtl/program_ram_loader.sv | 105 ++++++++++
 tb/tb_program_ram_loader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/program_ram_loader_if.sv
// Host write stream plus CPU fetch port of the writable program store.
//   master : host/CPU side (drives load_start, wr_*, fetch_addr)
//   slave  : program_ram_loader (drives wr_ready, cpu_hold, load_*, words_loaded, fetch_data)
interface program_ram_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              load_start;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              wr_ready;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   words_loaded;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;

  modport master (
    output load_start, wr_valid, wr_data, wr_last, fetch_addr,
    input  wr_ready, cpu_hold, load_done, load_error, words_loaded, fetch_data
  );

  modport slave (
    input  load_start, wr_valid, wr_data, wr_last, fetch_addr,
    output wr_ready, cpu_hold, load_done, load_error, words_loaded, fetch_data
  );
endinterface

// File: rtl/program_ram_loader.sv
// Writable DEPTH x DATA_W program store for the 4-bit CPU.
// A load (load_start in IDLE) first fills every word with NOP_CODE (CLEAR),
// then accepts host words over wr_valid/wr_ready (LOAD) until wr_last or the
// store is full. The CPU is held and fed NOP_CODE for the whole load.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : program_ram_loader_if.slave (host stream + fetch port)
module program_ram_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16,
  parameter logic [DATA_W-1:0] NOP_CODE = 4'b0111
) (
  input  logic                 clk,
  input  logic                 rst_n,
  program_ram_loader_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD} state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

  state_t            state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   count;
  logic              done_q;
  logic              error_q;

  logic hs;         // word accepted this cycle
  logic last_slot;  // this word fills the final address
  logic finish;     // accepted word ends the load

  always_comb begin
    hs        = (state == LOAD) && bus.wr_valid;
    last_slot = (count == LAST_CNT);
    finish    = hs && (bus.wr_last || last_slot);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.load_start)    state_nx = CLEAR;
      CLEAR:   if (ptr == LAST_PTR)   state_nx = LOAD;
      LOAD:    if (finish)            state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  // Storage, pointer and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem     <= '{default: NOP_CODE};
      ptr     <= '0;
      count   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_start) begin
            ptr     <= '0;
            count   <= '0;
            error_q <= 1'b0;
          end
        end
        CLEAR: begin
          mem[ptr] <= NOP_CODE;
          ptr      <= ptr + 1'b1;  // wraps to 0 after the last address
        end
        LOAD: begin
          if (hs) begin
            mem[ptr] <= bus.wr_data;
            ptr      <= ptr + 1'b1;
            count    <= count + 1'b1;
            if (finish) done_q <= 1'b1;
            // Store filled without the host marking an end: overflow.
            if (!bus.wr_last && last_slot) error_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.cpu_hold     = (state != IDLE);
    bus.wr_ready     = (state == LOAD);
    bus.load_done    = done_q;
    bus.load_error   = error_q;
    bus.words_loaded = count;
    bus.fetch_data   = (state != IDLE) ? NOP_CODE : mem[bus.fetch_addr];
  end

endmodule

// File: tb/tb_program_ram_loader.sv
module tb_program_ram_loader;

  localparam logic [3:0] NOP = 4'b0111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   c0;
  logic [3:0] exp_q [$];

  always #5 clk = ~clk;

  program_ram_loader_if #(.ADDR_W(4), .DATA_W(4)) bus ();

  program_ram_loader #(
    .ADDR_W(4), .DATA_W(4), .DEPTH(16), .NOP_CODE(4'b0111)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sweep all fetch addresses: first n pop from the scoreboard, the rest are NOP.
  task automatic check_mem(input int n, input string tag);
    logic [3:0] e;
    for (int a = 0; a < 16; a++) begin
      bus.fetch_addr = 4'(a);
      #1;
      e = (a < n && exp_q.size() > 0) ? exp_q.pop_front() : NOP;
      check(tag, 8'(bus.fetch_data), 8'(e));
    end
    exp_q.delete();
  endtask

  task automatic start_load();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 40 && bus.wr_ready !== 1'b1; k++) tick();
    check("ready_timeout", 8'(bus.wr_ready), 8'd1);
  endtask

  task automatic send_word(input logic [3:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_last  = last;
    exp_q.push_back(d);
    for (int k = 0; k < 64 && !ok; k++) begin
      if (bus.wr_ready === 1'b1) ok = 1'b1;
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    check("handshake", 8'(ok), 8'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.load_start = 1'b0;
    bus.wr_valid   = 1'b0;
    bus.wr_data    = '0;
    bus.wr_last    = 1'b0;
    bus.fetch_addr = '0;

    // A: reset
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_hold",  8'(bus.cpu_hold),     8'd0);
    check("rst_ready", 8'(bus.wr_ready),     8'd0);
    check("rst_done",  8'(bus.load_done),    8'd0);
    check("rst_error", 8'(bus.load_error),   8'd0);
    check("rst_words", 8'(bus.words_loaded), 8'd0);
    check_mem(0, "rst_mem");

    // B: three-word load, ignored inputs during CLEAR and LOAD
    tick();
    c0 = cyc;
    start_load();
    check("clr_hold",  8'(bus.cpu_hold), 8'd1);
    check("clr_ready", 8'(bus.wr_ready), 8'd0);
    bus.load_start = 1'b1;
    bus.wr_valid   = 1'b1;
    bus.wr_data    = 4'hF;
    for (int k = 0; k < 5; k++) tick();
    bus.load_start = 1'b0;
    bus.wr_valid   = 1'b0;
    wait_ready();
    check("ready_cycle", 8'(cyc - c0), 8'd17);
    bus.load_start = 1'b1;
    tick(); tick();
    bus.load_start = 1'b0;
    check("load_no_restart", 8'(bus.wr_ready),     8'd1);
    check("load_words0",     8'(bus.words_loaded), 8'd0);
    send_word(4'b0000, 1'b0);
    send_word(4'b0001, 1'b0);
    send_word(4'b1010, 1'b1);
    check("b_done",  8'(bus.load_done),    8'd1);
    check("b_hold",  8'(bus.cpu_hold),     8'd0);
    check("b_ready", 8'(bus.wr_ready),     8'd0);
    check("b_words", 8'(bus.words_loaded), 8'd3);
    bus.fetch_addr = 4'd2;
    #1;
    check("b_fetch_now", 8'(bus.fetch_data), 8'h0A);
    tick();
    check("b_done_pulse", 8'(bus.load_done), 8'd0);
    check_mem(3, "b_mem");
    bus.wr_valid = 1'b1;
    bus.wr_data  = 4'h5;
    bus.wr_last  = 1'b1;
    tick(); tick(); tick();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    check("idle_wr_words", 8'(bus.words_loaded), 8'd3);
    check("idle_wr_done",  8'(bus.load_done),    8'd0);
    bus.fetch_addr = 4'd0;
    #1;
    check("idle_wr_mem0", 8'(bus.fetch_data), 8'h00);
    bus.fetch_addr = 4'd3;
    #1;
    check("idle_wr_mem3", 8'(bus.fetch_data), 8'(NOP));

    // C: overflow
    tick();
    start_load();
    wait_ready();
    for (int i = 0; i < 16; i++) send_word(4'(i), 1'b0);
    check("ovf_done",  8'(bus.load_done),    8'd1);
    check("ovf_error", 8'(bus.load_error),   8'd1);
    check("ovf_ready", 8'(bus.wr_ready),     8'd0);
    check("ovf_words", 8'(bus.words_loaded), 8'd16);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 4'h0;
    tick(); tick(); tick();
    bus.wr_valid = 1'b0;
    check("ovf_extra_ready", 8'(bus.wr_ready),     8'd0);
    check("ovf_extra_words", 8'(bus.words_loaded), 8'd16);
    check("ovf_done_pulse",  8'(bus.load_done),    8'd0);
    check("ovf_error_stick", 8'(bus.load_error),   8'd1);
    check_mem(16, "ovf_mem");

    // D: reload after error, random gaps, NOP fetch while held
    tick();
    start_load();
    check("d_error_clr", 8'(bus.load_error), 8'd0);
    check("d_hold",      8'(bus.cpu_hold),   8'd1);
    bus.fetch_addr = 4'd9;
    #1;
    check("d_fetch_hold", 8'(bus.fetch_data), 8'(NOP));
    wait_ready();
    for (int w = 0; w < 5; w++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        bus.wr_valid   = 1'b0;
        bus.wr_data    = 4'($urandom_range(0, 15));
        bus.wr_last    = 1'($urandom_range(0, 1));
        bus.fetch_addr = 4'($urandom_range(0, 15));
        #1;
        check("gap_fetch_nop", 8'(bus.fetch_data), 8'(NOP));
        check("gap_hold",      8'(bus.cpu_hold),   8'd1);
        tick();
      end
      bus.wr_last = 1'b0;
      send_word(4'($urandom_range(0, 15)), (w == 4));
    end
    check("d_done",  8'(bus.load_done),    8'd1);
    check("d_words", 8'(bus.words_loaded), 8'd5);
    check("d_error", 8'(bus.load_error),   8'd0);
    tick();
    check_mem(5, "d_mem");

    // E: minimum one-word load and restart on the load_done cycle
    tick();
    c0 = cyc;
    start_load();
    wait_ready();
    send_word(4'h9, 1'b1);
    check("min_latency", 8'(cyc - c0),         8'd18);
    check("min_done",    8'(bus.load_done),    8'd1);
    check("min_words",   8'(bus.words_loaded), 8'd1);
    bus.fetch_addr = 4'd0;
    #1;
    check("min_mem0", 8'(bus.fetch_data), 8'(exp_q.pop_front()));
    exp_q.delete();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    check("restart_hold",  8'(bus.cpu_hold),     8'd1);
    check("restart_words", 8'(bus.words_loaded), 8'd0);

    // F: reset mid-load
    wait_ready();
    send_word(4'h3, 1'b0);
    send_word(4'hC, 1'b0);
    check("mid_words", 8'(bus.words_loaded), 8'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_hold",  8'(bus.cpu_hold),     8'd0);
    check("mid_rst_ready", 8'(bus.wr_ready),     8'd0);
    check("mid_rst_words", 8'(bus.words_loaded), 8'd0);
    check("mid_rst_done",  8'(bus.load_done),    8'd0);
    exp_q.delete();
    check_mem(0, "mid_rst_mem");
    rst_n = 1'b1;
    tick();
    check("post_rst_hold",  8'(bus.cpu_hold), 8'd0);
    check("post_rst_ready", 8'(bus.wr_ready), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
